// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the parallel-in, serial-out bit serializer.
// BIT_SERIALIZER_PARITY_EN appends one even-parity bit to every frame.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int SER_GAP_W = 4;

  function automatic int frame_len(input int w);
`ifdef BIT_SERIALIZER_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage: W-bit words in over valid/ready, one bit per clock out,
// with a GAP-cycle idle gap after each frame. BIT_SERIALIZER_PARITY_EN adds an even-parity bit.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy
);

  localparam int                   F        = frame_len(W);
  localparam int                   CNT_W    = $clog2(W + 2);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(F - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [SER_GAP_W-1:0] GAP_LAST = SER_GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [SER_GAP_W-1:0] GAP_ONE  = SER_GAP_W'(1);

  ser_state_t           r_state;
  logic [W-1:0]         r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic [SER_GAP_W-1:0] r_gap_cnt;
  logic                 r_sout;
  logic                 r_sout_valid;
  logic                 r_busy;

  logic         w_last;
  logic         w_accept;
  logic         w_first_bit;
  logic         w_data_bit;
  logic         w_next_bit;
  logic [W-1:0] w_load_rest;
  logic [W-1:0] w_shifted;

  // The first bit goes straight to sout on accept; r_shift keeps only the remaining bits.
  assign w_last      = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign din_ready   = !rst && ((r_state == IDLE) || ((GAP == 0) && w_last));
  assign w_accept    = din_valid && din_ready;
  assign w_first_bit = (MSB_FIRST != 0) ? din[W-1] : din[0];
  assign w_load_rest = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
  assign w_data_bit  = (MSB_FIRST != 0) ? r_shift[W-1] : r_shift[0];
  assign w_shifted   = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  logic r_par;
  assign w_next_bit = (r_cnt == CNT_W'(W - 1)) ? r_par : w_data_bit;
`else
  assign w_next_bit = w_data_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_gap_cnt    <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state      <= SHIFT;
      r_shift      <= w_load_rest;
      r_cnt        <= '0;
      r_sout       <= w_first_bit;
      r_sout_valid <= 1'b1;
      r_busy       <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      r_par        <= ^din;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_last) begin
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            if (GAP > 0) begin
              r_state   <= bit_serializer_pkg::GAP;
              r_gap_cnt <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_shift <= w_shifted;
            r_sout  <= w_next_bit;
          end
        end
        bit_serializer_pkg::GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_ONE;
          end
        end
        IDLE:    ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB/GAP0, LSB/GAP0, MSB/GAP3) checked every cycle
// against a frame-occupancy model and an expected-bit queue built from accepted words.
module tb_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din [3];
  logic       dv  [3];
  logic       rdy [3];
  logic       so  [3];
  logic       sv  [3];
  logic       bz  [3];

  int G [3] = '{0, 0, 3};
  int M [3] = '{1, 0, 1};

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int F_LEN = 9;
`else
  localparam int F_LEN = 8;
`endif

  int   errors = 0;
  int   checks = 0;
  int   rem    = 0;   // busy cycles still owed by the instance under test, this cycle included
  logic exp_q [$];

  bit_serializer #(.W(8), .MSB_FIRST(1), .GAP(0)) u_msb (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]),
    .din_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]));

  bit_serializer #(.W(8), .MSB_FIRST(0), .GAP(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]),
    .din_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]));

  bit_serializer #(.W(8), .MSB_FIRST(1), .GAP(3)) u_gap (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]),
    .din_ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int k, input logic [7:0] d);
    for (int i = 0; i < 8; i++) exp_q.push_back((M[k] != 0) ? d[7-i] : d[i]);
`ifdef BIT_SERIALIZER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endtask

  // Called at a falling edge: check this cycle's outputs, then drive inputs for the next rising edge.
  task automatic step(input int k, input logic v, input logic [7:0] d);
    logic exp_rdy;
    logic exp_sv;
    logic eb;
    exp_rdy = (rem == 0) || (G[k] == 0 && rem == 1);
    exp_sv  = (rem > G[k]);
    chk("din_ready", rdy[k], exp_rdy);
    chk("busy", bz[k], rem > 0);
    chk("sout_valid", sv[k], exp_sv);
    if (exp_sv) begin
      eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      chk("sout_bit", so[k], eb);
    end else begin
      chk("sout_idle", so[k], 1'b0);
    end
    dv[k]  = v;
    din[k] = d;
    if (v && exp_rdy) begin
      rem = F_LEN + G[k];
      load_word(k, d);
    end else if (rem > 0) begin
      rem--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00;
      dv[k]  = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", rdy[k], 1'b0);
      chk("rst_valid", sv[k], 1'b0);
      chk("rst_busy", bz[k], 1'b0);
      chk("rst_sout", so[k], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // MSB-first single word B2 -> 1,0,1,1,0,0,1,0
    step(0, 1'b1, 8'hB2);
    idle(0, 12);

    // Parity words (parity bit appended only when the feature is built in)
    step(0, 1'b1, 8'h07);
    idle(0, 11);
    step(0, 1'b1, 8'h03);
    idle(0, 11);

    // LSB-first back-to-back with valid held: 01 then 80
    step(1, 1'b1, 8'h01);
    for (int i = 0; i < F_LEN; i++) step(1, 1'b1, 8'h80);
    idle(1, 12);

    // Gap insertion: two words offered continuously
    step(2, 1'b1, 8'hA5);
    for (int i = 0; i < F_LEN + 3; i++) step(2, 1'b1, 8'h3C);
    idle(2, 16);

    // Handshake abuse: valid pulses with changing data mid-frame
    step(0, 1'b1, 8'h5A);
    for (int i = 0; i < 6; i++) step(0, logic'(i % 2), 8'($urandom_range(0, 255)));
    idle(0, 12);
    step(2, 1'b1, 8'hC3);
    for (int i = 0; i < 10; i++) step(2, logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    idle(2, 16);

    // Randomized traffic on every instance
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 150; i++)
        step(k, logic'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
      idle(k, 16);
      chk("drain", exp_q.size() == 0, 1'b1);
    end

    // Reset mid-frame: A5 accepted, rst held 3 cycles, frame abandoned
    step(0, 1'b1, 8'hA5);
    idle(0, 3);
    rst   = 1'b1;
    dv[0] = 1'b0;
    @(negedge clk);
    chk("midrst_valid", sv[0], 1'b0);
    chk("midrst_busy", bz[0], 1'b0);
    chk("midrst_ready", rdy[0], 1'b0);
    chk("midrst_sout", so[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rem = 0;
    exp_q.delete();
    @(negedge clk);
    step(0, 1'b1, 8'hB2);
    idle(0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
